// File: rtl/mil_pkg.sv
// Shared constants and state encoding for the Manchester-II word path.
// Used by the transmitter (mil_txd_word) and by the receive stage's
// sync-length check, so the timing constants live here rather than in
// either block.
//   BIT_CLK     : clk cycles per bit time
//   HALF_CLK    : clk cycles per half-bit (BIT_CLK must be even)
//   SYNC_HALVES : half-bits spent on the sync pattern
//   DATA_BITS   : payload bits per word
//   WORD_HALVES : half-bits per word (sync + data + parity)
package mil_pkg;

  localparam int FCLK_HZ     = 50_000_000;
  localparam int TX_BPS      = 1_000_000;
  localparam int BIT_CLK     = FCLK_HZ / TX_BPS;
  localparam int HALF_CLK    = BIT_CLK / 2;
  localparam int SYNC_HALVES = 6;
  localparam int DATA_BITS   = 16;
  localparam int WORD_HALVES = 40;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_PAR  = 2'd3;

  typedef logic [DATA_BITS-1:0] mil_word_t;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity_bit(input mil_word_t d);
    return ~^d;
  endfunction

endpackage

// File: rtl/mil_half_tick.sv
// Half-bit timebase for the Manchester transmitter.
// Counts 0..HALF-1 while run is high and wraps; ce_half marks the last clk
// of each half-bit. restart forces the count back to 0 so a newly accepted
// word always starts on a fresh half-bit, even back-to-back.
// Ports:
//   clk, rst  : clock, asynchronous active-high clear
//   run       : count enable (a word is on the line)
//   restart   : synchronous return to count 0
//   ce_half   : high in the last clk of each half-bit
module mil_half_tick #(
  parameter int HALF = mil_pkg::HALF_CLK
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic ce_half
);

  localparam logic [5:0] LAST = 6'(HALF - 1);

  logic [5:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if (restart) begin
      cnt <= 6'd0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? 6'd0 : cnt + 6'd1;
    end
  end

  assign ce_half = run & (cnt == LAST);

endmodule

// File: rtl/mil_txd_word.sv
// MIL-STD-1553-style Manchester-II word transmitter.
// Sends a 3-bit-time sync, 16 data bits MSB first and an odd-parity bit
// (20 bit times) on a differential pair. Words may follow each other with
// no gap when a new start is accepted in the last clk of the parity bit.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   tx_start   : send request, taken only while tx_ready=1
//   tx_dat     : word to send, latched on acceptance
//   tx_cw      : 1 = command/status sync, 0 = data sync
//   tx_ready   : a start would be accepted this cycle
//   tx_busy    : a word is on the line
//   tx_done    : pulse in the last clk of the parity bit
//   TXP, TXN   : line drive; high = 10, low = 01, idle = 00
//
// state | meaning
// IDLE  | line idle (00), waiting for a start
// SYNC  | half-bits 0..5: sync pattern, polarity from tx_cw
// DATA  | half-bits 6..37: 16 Manchester data bits from the shift register
// PAR   | half-bits 38..39: odd-parity bit
module mil_txd_word
  import mil_pkg::*;
#(
  parameter int Fclk  = 50_000_000,
  parameter int TXvel = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [15:0] tx_dat,
  input  logic        tx_cw,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        TXP,
  output logic        TXN
);

  localparam int HALF = (Fclk / TXvel) / 2;

  localparam logic [5:0] IDX_SYNC_MID  = 6'(SYNC_HALVES / 2);
  localparam logic [5:0] IDX_SYNC_LAST = 6'(SYNC_HALVES - 1);
  localparam logic [5:0] IDX_DATA_LAST = 6'(WORD_HALVES - 3);
  localparam logic [5:0] IDX_LAST      = 6'(WORD_HALVES - 1);

  logic [1:0] state, state_n;
  logic [5:0] idx, idx_n;
  mil_word_t  sr, sr_n;
  logic       par, par_n;
  logic       cw, cw_n;
  logic       ce_half;
  logic       word_end;
  logic       accept;
  logic       level_n;
  logic       drive_n;

  mil_half_tick #(.HALF(HALF)) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (tx_busy),
    .restart (accept),
    .ce_half (ce_half)
  );

  assign word_end = (state == ST_PAR) & ce_half & (idx == IDX_LAST);
  assign tx_ready = (state == ST_IDLE) | word_end;
  assign accept   = tx_start & tx_ready;
  assign tx_done  = word_end;
  assign tx_busy  = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    sr_n    = sr;
    par_n   = par;
    cw_n    = cw;
    if (accept) begin
      state_n = ST_SYNC;
      idx_n   = 6'd0;
      sr_n    = tx_dat;
      par_n   = odd_parity_bit(tx_dat);
      cw_n    = tx_cw;
    end else if (word_end) begin
      state_n = ST_IDLE;
      idx_n   = 6'd0;
    end else if (ce_half && (state != ST_IDLE)) begin
      idx_n = idx + 6'd1;
      if ((state == ST_SYNC) && (idx == IDX_SYNC_LAST)) state_n = ST_PAR - 2'd1;
      if (state == ST_DATA) begin
        // Shift after the second half of each bit so sr[MSB] is the next bit.
        if (idx[0]) sr_n = {sr[DATA_BITS-2:0], 1'b0};
        if (idx == IDX_DATA_LAST) state_n = ST_PAR;
      end
    end
  end

  // Line level is decoded from the next-state values so the registered
  // outputs change on the same edge as the state they belong to.
  always_comb begin
    level_n = 1'b0;
    drive_n = 1'b0;
    case (state_n)
      ST_SYNC: begin
        drive_n = 1'b1;
        level_n = (idx_n < IDX_SYNC_MID) ? cw_n : ~cw_n;
      end
      ST_DATA: begin
        drive_n = 1'b1;
        level_n = idx_n[0] ? ~sr_n[DATA_BITS-1] : sr_n[DATA_BITS-1];
      end
      ST_PAR: begin
        drive_n = 1'b1;
        level_n = idx_n[0] ? ~par_n : par_n;
      end
      default: begin
        drive_n = 1'b0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 6'd0;
      sr    <= '0;
      par   <= 1'b0;
      cw    <= 1'b0;
      TXP   <= 1'b0;
      TXN   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sr    <= sr_n;
      par   <= par_n;
      cw    <= cw_n;
      TXP   <= drive_n & level_n;
      TXN   <= drive_n & ~level_n;
    end
  end

endmodule

// File: doc/mil_txd_word.md
Name: mil_txd_word

Overview:
- MIL-STD-1553-style Manchester-II word transmitter. It drives the differential line pair (TXP/TXN) that the receive stage samples as In_P/In_N.
- It accepts a 16-bit word plus a command/data flag through a ready/start handshake.
- For each word it emits a 3-bit-time sync, 16 Manchester data bits (MSB first) and one odd-parity bit, for 20 bit times in total.
- Words can be sent back-to-back with no gap, forming a contiguous message.

Parameters:
- Fclk, 50000000, system clock frequency in Hz.
- TXvel, 1000000, line bit rate in bit/s. One bit time is Fclk/TXvel = 50 clk; HALF = 25 clk. Fclk/TXvel must be even.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tx_start  in  1  request to send a word; sampled only while tx_ready=1.
- tx_dat  in  16  word to send; latched on an accepted start.
- tx_cw  in  1  1 = command/status sync, 0 = data sync; latched on an accepted start.
- tx_ready  out  1  block can accept a start in this cycle.
- tx_busy  out  1  a word is on the line.
- tx_done  out  1  one-cycle pulse in the last clk of the parity bit.
- TXP  out  1  positive line drive.
- TXN  out  1  negative line drive.

Behaviour:
- Reset: asynchronous; takes effect immediately, including mid-word.
  - TXP=0, TXN=0, tx_busy=0, tx_done=0, tx_ready=1 (after release); FSM returns to IDLE.
  - Counters and shift register are cleared; a partially sent word is abandoned.
- Line encoding:
  - Active high level: TXP=1, TXN=0. Active low level: TXP=0, TXN=1.
  - Idle: TXP=TXN=0. TXP=TXN=1 is never driven.
- Accept: start is accepted at the clk edge where tx_start=1 and tx_ready=1.
  - tx_dat and tx_cw are latched at that edge.
  - The first sync level appears on TXP/TXN at the same edge; outputs are registered, so latency is 1 clk from the sampled start.
- FSM states: IDLE, SYNC, DATA, PAR.
  - IDLE: accepted start -> SYNC.
  - SYNC, 150 clk:
    - tx_cw=1: high for 75 clk, then low for 75 clk.
    - tx_cw=0: low for 75 clk, then high for 75 clk.
  - DATA, 16 x 50 clk, MSB first via a left shift. Bit 1 = high 25 clk then low 25 clk; bit 0 = low then high.
  - PAR, 50 clk: one Manchester bit P, chosen so that popcount(tx_dat)+P is odd (P = ~^tx_dat).
  - Word length is exactly 1000 clk (20 bit times).
- Timing: a 6-bit half-bit counter runs 0..HALF-1 and wraps; a 6-bit half-bit index counts 0..39 within the word (sync = indices 0..5).
  - All level transitions occur only at half-bit boundaries.
  - No counter may overflow its width.
- tx_ready = (state==IDLE) | (last clk of PAR).
- tx_done = 1 in the last clk of PAR only.
- tx_busy = 1 from the accept edge through the last clk of PAR.
- Back-to-back: a start accepted in the last clk of PAR begins SYNC on the next edge.
  - There are no idle cycles between words and tx_busy stays 1.
  - The new tx_dat/tx_cw are latched at that edge; tx_done still pulses for the finishing word.
- End of word, no new start: the next edge gives IDLE, TXP=TXN=0, tx_busy=0.
- tx_start while tx_ready=0: ignored, with no effect on the current word and no queuing.
- tx_dat/tx_cw changes after acceptance: no effect until the next accept.

Decomposition:
- Shared package mil_pkg:
  - constants BIT_CLK = Fclk/TXvel, HALF_CLK = BIT_CLK/2, SYNC_HALVES = 6, DATA_BITS = 16, WORD_HALVES = 40.
  - FSM state encoding (IDLE/SYNC/DATA/PAR, 2 bits).
  - These are reused by the receive stage's sync-length check.
- One sub-module: mil_half_tick.
  - Half-bit counter with synchronous restart on an accepted start.
  - Asynchronous clear on rst.
  - Outputs ce_half (last clk of each half-bit).
  - Parameter HALF.

Test Plan:
- tx_cw=1, tx_dat=16'hA5A5, single start:
  - TXP high 75 clk, low 75 clk;
  - then bits 1,0,1,0,0,1,0,1,... each 25/25 clk;
  - parity bit P=1 (8 ones) -> high then low;
  - tx_done exactly 1000 clk after the accept edge; idle afterwards.
- tx_cw=0, tx_dat=16'h0001 -> sync low 75 / high 75; P=0 (popcount 1) -> low then high; TXP&TXN never both 1 throughout.
- Back-to-back: second start with tx_dat=16'hFFFF, tx_cw=0 held in the tx_done cycle:
  - second sync begins on the next clk;
  - tx_busy continuous for 2000 clk;
  - P=1.
- tx_start pulsed at clk 300 of a word -> ignored; the word is bit-identical to the reference waveform and no second word follows.
- rst asserted at clk 500 of a word -> TXP=TXN=0 and tx_busy=0 asynchronously; after release, tx_ready=1 and a new start sends a full, correct 1000-clk word.
- Loopback into the receive stage (TXP->In_P, TXN->In_N) with tx_dat=16'h1234, tx_cw=1 -> receiver ok_SY asserts during sync; receiver CW_DW=1; sr_dat=16'h1234.
